// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the memory port arbiter.
// Holds the arbiter state encoding, grant identifiers and the default memory latency.
package mem_port_arbiter_pkg;

    localparam int unsigned LAT_DEFAULT = 2;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t DM_ACC = 2'd1;
    localparam arb_state_t IF_ACC = 2'd2;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the fetch stage (IF) and the MEM stage (DM).
// Round-robin between the two ports; each granted access lasts LAT cycles and finishes
// with a one-cycle valid pulse on the winning port.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   if_req/if_addr         fetch request and address (held until if_valid)
//   if_flush               kills the outstanding fetch
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request (held until dm_valid)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port
//   if_valid/if_rdata      fetch completion pulse and instruction word
//   dm_valid/dm_rdata      data completion pulse and load data
//   stall_if/stall_mem     pipeline hold signals
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LAT = LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

    arb_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    // A port that just completed sits out one cycle; a flushed fetch is not eligible.
    logic if_elig, dm_elig;
    assign if_elig = if_req & ~if_valid_q & ~if_flush;
    assign dm_elig = dm_req & ~dm_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // DM wins a tie only when IF had the previous grant.
                if (dm_elig && (!if_elig || last_grant_q == GRANT_IF)) begin
                    state_d      = DM_ACC;
                    cnt_d        = CNT_LOAD;
                    last_grant_d = GRANT_DM;
                end else if (if_elig) begin
                    state_d      = IF_ACC;
                    cnt_d        = CNT_LOAD;
                    last_grant_d = GRANT_IF;
                end
            end
            DM_ACC: begin
                // Stores run to completion regardless of dm_req.
                if (cnt_q == 3'd0) begin
                    state_d    = IDLE;
                    dm_valid_d = 1'b1;
                    if (!dm_we) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            IF_ACC: begin
                // Flush beats completion in the same cycle.
                if (if_flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= GRANT_IF;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_rdata_q   <= 32'd0;
            dm_rdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Memory outputs decode straight from the state register, so reset clears them
    // (including an in-flight write enable) without waiting for a clock edge.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state_q)
            DM_ACC: begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            IF_ACC: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            default: ;
        endcase
    end

    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_mem = dm_req & ~dm_valid_q;
    assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: LAT, default 2, memory access latency in cycles (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch-stage read request, held until if_valid.
REQ-005 if_addr  input  32  fetch address, stable while if_req.
REQ-006 if_flush  input  1  branch-taken/PC-write kill of the outstanding fetch.
REQ-007 dm_req  input  1  MEM-stage load/store request, held until dm_valid.
REQ-008 dm_we  input  1  1 = store, 0 = load.
REQ-009 dm_addr  input  32  data address; dm_wdata input 32 store data; both stable while dm_req.
REQ-010 mem_en  output  1  shared single-port memory enable; mem_we output 1; mem_addr output 32; mem_wdata output 32.
REQ-011 mem_rdata  input  32  memory read data, valid in the last access cycle.
REQ-012 if_valid  output  1  one-cycle fetch completion; if_rdata output 32 instruction word.
REQ-013 dm_valid  output  1  one-cycle data completion; dm_rdata output 32 load data.
REQ-014 stall_if  output  1  hold PC and IF/ID register; stall_mem output 1 hold EX/MEM and earlier stages.

Function
REQ-015 FSM states: IDLE, DM_ACC, IF_ACC; 3-bit down-counter cnt; 1-bit last_grant (IF/DM).
REQ-016 IDLE, only dm_req eligible -> DM_ACC; only if_req eligible -> IF_ACC; none -> IDLE.
REQ-017 IDLE, both eligible: grant DM when last_grant = IF, grant IF when last_grant = DM (round-robin).
REQ-018 A request is ineligible in the cycle its own valid is high (completion cool-down).
REQ-019 On grant, cnt loads LAT-1 and last_grant records the winner.
REQ-020 In DM_ACC/IF_ACC: mem_en = 1, mem_addr = granted address; mem_we = dm_we and mem_wdata = dm_wdata in DM_ACC only; in IDLE all mem_* outputs are 0.
REQ-021 cnt decrements each access cycle; at cnt = 0 the next edge returns to IDLE, pulses the port's valid for exactly one cycle and registers mem_rdata into that port's rdata.
REQ-022 Latency: request in cycle 0 (IDLE) -> access cycles 1..LAT -> valid in cycle LAT+1.
REQ-023 rdata outputs hold their last value until the next completion of that port.
REQ-024 Store completion also pulses dm_valid; dm_rdata is unchanged by a store.
REQ-025 stall_mem = dm_req & ~dm_valid (combinational).
REQ-026 stall_if = (if_req & ~if_valid) | stall_mem (combinational).
REQ-027 if_flush in IF_ACC: next state IDLE, no if_valid, if_rdata unchanged, last_grant unchanged.
REQ-028 if_flush in IDLE: if_req ineligible that cycle; if_flush in DM_ACC: no effect.
REQ-029 Stores are never aborted; dm_req deassertion mid-access does not shorten the access.
REQ-030 Simultaneous if_flush and IF completion (cnt = 0): flush wins, no if_valid.

Reset
REQ-031 Reset asserted: state IDLE, cnt 0, last_grant = IF, if_valid/dm_valid 0, if_rdata/dm_rdata 0, mem_* 0.
REQ-032 Reset mid-access aborts the access immediately; any in-flight store write enable drops asynchronously.
REQ-033 First eligible cycle after reset release behaves as IDLE; simultaneous requests go to DM.

Structure
REQ-034 State encoding (IDLE, DM_ACC, IF_ACC) and the LAT default belong in the shared ARM pipeline package.
REQ-035 Single module; no sub-module required (counter and FSM are inline).

Verification
REQ-036 LAT=2, if_req alone at cycle 0, mem_rdata=0xE3A01005 -> mem_en cycles 1-2, if_valid at cycle 3 with if_rdata=0xE3A01005, stall_if high cycles 0-2.
REQ-037 if_req and dm_req (load, 0x100) together after reset -> DM granted first; dm_valid cycle 3, IF access cycles 4-5 (cool-down cycle 3 makes dm ineligible), if_valid cycle 6; stall_if high cycles 0-5.
REQ-038 Both held continuously across three transactions -> grants alternate DM, IF, DM.
REQ-039 Store dm_we=1, addr 0x20, data 0xDEADBEEF -> mem_we=1 cycles 1-2 with that addr/data; dm_valid cycle 3; dm_rdata unchanged.
REQ-040 if_flush in cycle 2 of an IF access -> IDLE cycle 3, no if_valid; re-issued if_req completes normally 3 cycles later.
REQ-041 reset asserted in cycle 1 of a store -> mem_we 0 immediately, all outputs at reset values, store never completes.
